// File: rtl/axis_sync_fifo_if.sv
// AXI Stream beat interface (tvalid/tready/tdata) shared by the FIFO's
// upstream and downstream ports.
interface axis_if #(
  parameter int unsigned TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through AXI Stream FIFO with pipeline flush; sits between
// fetch and decode to absorb bursts.
module axis_sync_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_if.s                      axis_sif,
  axis_if.m                      axis_mif,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = AW + 1;
  localparam int unsigned TDATA_WIDTH = $bits(axis_mif.tdata);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "axis_sync_fifo: DEPTH must be a power of two and at least 2");
  end
  if ($bits(axis_sif.tdata) != TDATA_WIDTH) begin : g_bad_width
    $fatal(1, "axis_sync_fifo: axis_sif and axis_mif TDATA_WIDTH differ");
  end

  logic [TDATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]          wp_q, wp_d;
  logic [CW-1:0]          rp_q, rp_d;
  logic [CW-1:0]          count_d;
  logic                   rdy_q, rdy_d;
  logic                   push, pop;

  assign count           = wp_q - rp_q;
  assign axis_mif.tvalid = (wp_q != rp_q) && !flush;
  assign axis_mif.tdata  = mem_q[rp_q[AW-1:0]];
  assign axis_sif.tready = rdy_q && !flush;

  assign push = axis_sif.tvalid && axis_sif.tready;
  assign pop  = axis_mif.tvalid && axis_mif.tready;

  always_comb begin
    wp_d    = wp_q + CW'(push);
    rp_d    = rp_q + CW'(pop);
    // flush empties the FIFO by catching rp up to wp; contents stay in place
    if (flush) begin
      rp_d = wp_q;
    end
    count_d = wp_d - rp_d;
    rdy_d   = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      rdy_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      rdy_q <= rdy_d;
      if (push) begin
        mem_q[wp_q[AW-1:0]] <= axis_sif.tdata;
      end
    end
  end
endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo: constant vector table for reset and
// fill/drain, plus a queue-based reference model for the remaining traffic.
module tb_axis_sync_fifo;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  axis_if #(.TDATA_WIDTH(8)) sif_bus ();
  axis_if #(.TDATA_WIDTH(8)) mif_bus ();

  axis_sync_fifo #(
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .axis_sif(sif_bus),
    .axis_mif(mif_bus),
    .flush   (flush),
    .count   (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] sb[$];
  logic       m_rdy = 1'b0;
  logic       c_rst, c_fl, c_push, c_pop;
  int         pushes = 0;
  int         pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare outputs against the model before the edge.
  task automatic apply(input logic r_, input logic f_, input logic v_, input logic [7:0] d_,
                       input logic rd_);
    logic e_rdy, e_vld;
    rst = r_;
    flush = f_;
    sif_bus.tvalid = v_;
    sif_bus.tdata = d_;
    mif_bus.tready = rd_;
    #1;
    e_rdy = m_rdy && !f_;
    e_vld = (sb.size() != 0) && !f_;
    check("model_tready", 32'(sif_bus.tready), 32'(e_rdy));
    check("model_tvalid", 32'(mif_bus.tvalid), 32'(e_vld));
    check("model_count", 32'(count), 32'(sb.size()));
    if (e_vld) check("model_tdata", 32'(mif_bus.tdata), 32'(sb[0]));
    c_rst = r_;
    c_fl = f_;
    c_push = v_ && e_rdy;
    c_pop = e_vld && rd_;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (c_rst) begin
      sb.delete();
      m_rdy = 1'b0;
    end else if (c_fl) begin
      sb.delete();
      m_rdy = 1'b1;
    end else begin
      if (c_pop) begin
        void'(sb.pop_front());
        pops++;
      end
      if (c_push) begin
        sb.push_back(sif_bus.tdata);
        pushes++;
      end
      m_rdy = (sb.size() != DEPTH);
    end
  endtask

  task automatic cycle(input logic r_, input logic f_, input logic v_, input logic [7:0] d_,
                       input logic rd_);
    apply(r_, f_, v_, d_, rd_);
    advance();
  endtask

  typedef struct {
    logic       rst;
    logic       fl;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_rdy;
    logic       e_vld;
    logic       chk_d;
    logic [7:0] e_d;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // rst, fl, v, d, r, e_rdy, e_vld, chk_d, e_d, e_cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

    rst = 1'b1;
    flush = 1'b0;
    sif_bus.tvalid = 1'b0;
    sif_bus.tdata = 8'h00;
    mif_bus.tready = 1'b0;
    c_rst = 1'b1;
    c_fl = 1'b0;
    c_push = 1'b0;
    c_pop = 1'b0;
    advance();

    // Reset release and fill/drain against constant vectors
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_tready", i), 32'(sif_bus.tready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_tvalid", i), 32'(mif_bus.tvalid), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_d) begin
        check($sformatf("vec%0d_tdata", i), 32'(mif_bus.tdata), 32'(vecs[i].e_d));
      end
      advance();
    end

    // Streaming across several pointer wraps: count holds at 1 after the first beat
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
      if (i > 0) begin
        check("stream_tvalid", 32'(mif_bus.tvalid), 32'd1);
        check("stream_count", 32'(count), 32'd1);
        check("stream_tdata", 32'(mif_bus.tdata), 32'(8'h40 + i - 1));
      end
      advance();
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Random valid/ready traffic
    begin
      int         base;
      int         cyc;
      logic [7:0] nd;
      base = pushes;
      cyc = 0;
      nd = 8'h00;
      while ((pushes - base) < 1000 && cyc < 20000) begin
        apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), nd, 1'($urandom_range(0, 1)));
        if (c_push) nd = nd + 8'd1;
        advance();
        cyc++;
      end
      if (cyc >= 20000) check("random_budget", 32'(pushes - base), 32'd1000);
      cyc = 0;
      while (sb.size() != 0 && cyc < 50) begin
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc++;
      end
      check("random_drained", 32'(count), 32'd0);
    end

    // Flush with upstream valid during the flush cycle
    cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    check("flush_tready", 32'(sif_bus.tready), 32'd0);
    check("flush_tvalid", 32'(mif_bus.tvalid), 32'd0);
    advance();
    apply(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    check("post_flush_count", 32'(count), 32'd0);
    check("post_flush_tvalid", 32'(mif_bus.tvalid), 32'd0);
    check("post_flush_tready", 32'(sif_bus.tready), 32'd1);
    advance();
    apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("post_flush_data", 32'(mif_bus.tdata), 32'h11);
    advance();
    apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("post_flush_only", 32'(mif_bus.tvalid), 32'd0);
    advance();

    // Reset during a simultaneous push/pop with two beats stored
    cycle(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h23, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 8'h24, 1'b1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_tvalid", 32'(mif_bus.tvalid), 32'd0);
    check("mid_rst_tready", 32'(sif_bus.tready), 32'd0);
    advance();
    apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("mid_rst_ready_back", 32'(sif_bus.tready), 32'd1);
    check("mid_rst_no_stale", 32'(mif_bus.tvalid), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
